seq_gen_7bit: RTL and testbench

Serial pattern transmitter that emits the 7-bit frame 1011101, MSB first, one bit per clock, a programmable number of times with optional zero-gap cycles between frames. It is the source end of the 7-bit sequence-detector link. Its serial output drives the detector's `in` input, so the pair can be exercised closed-loop. A start/busy/done handshake lets a controller or testbench request bursts of frames.

---
 rtl/seq_pkg.sv | 15 +
 rtl/down_counter.sv | 39 +++
 rtl/seq_gen_7bit.sv | 148 ++++++++++++++
 tb/tb_seq_gen_7bit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the 7-bit sequence generator/detector link:
// frame pattern, frame length and the FSM state encoding.
package seq_pkg;

  localparam int SEQ_LEN = 7;
  localparam logic [SEQ_LEN-1:0] SEQ_PATTERN = 7'b1011101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    GAP   = 3'd2,
    DONE  = 3'd3
  } seq_state_e;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with a zero flag.
// Load wins over decrement, and decrementing stops at zero.
module down_counter #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign value = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/seq_gen_7bit.sv
// Serial frame transmitter: sends PATTERN MSB first, 'count' times per burst,
// with GAP_CYCLES idle zeros between frames and a start/busy/done handshake.
module seq_gen_7bit
  import seq_pkg::*;
#(
  parameter logic [SEQ_LEN-1:0] PATTERN    = SEQ_PATTERN,
  parameter int                 GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] count,
  input  logic       abort,
  output logic       out,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  localparam logic [2:0] IDX_TOP  = 3'(SEQ_LEN - 1);
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  seq_state_e state_q;
  seq_state_e state_d;

  logic       idx_load;
  logic       idx_dec;
  logic [2:0] idx_val;
  logic       idx_zero;

  logic       gap_load;
  logic       gap_dec;
  logic       gap_zero;
  logic [3:0] gap_val_unused;

  logic       rep_load;
  logic [3:0] rep_load_val;
  logic       rep_dec;
  logic       rep_zero;
  logic [3:0] rep_val_unused;

  down_counter #(.WIDTH(3), .RESET_VAL(IDX_TOP)) u_bit_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (idx_load),
    .load_val (IDX_TOP),
    .dec      (idx_dec),
    .value    (idx_val),
    .zero     (idx_zero)
  );

  down_counter #(.WIDTH(4), .RESET_VAL(4'd0)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .value    (gap_val_unused),
    .zero     (gap_zero)
  );

  // Holds the number of frames still owed after the one being shifted,
  // so a zero flag at the last bit means the burst is complete.
  down_counter #(.WIDTH(4), .RESET_VAL(4'd0)) u_rep_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rep_load),
    .load_val (rep_load_val),
    .dec      (rep_dec),
    .value    (rep_val_unused),
    .zero     (rep_zero)
  );

  always_comb begin
    state_d      = state_q;
    idx_load     = 1'b0;
    idx_dec      = 1'b0;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;
    rep_load     = 1'b0;
    rep_load_val = 4'd0;
    rep_dec      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (count != 4'd0)) begin
          rep_load     = 1'b1;
          rep_load_val = count - 4'd1;
          idx_load     = 1'b1;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          rep_load = 1'b1;
          idx_load = 1'b1;
          state_d  = IDLE;
        end else if (idx_zero) begin
          idx_load = 1'b1;
          if (rep_zero) begin
            state_d = DONE;
          end else begin
            rep_dec = 1'b1;
            if (GAP_CYCLES > 0) begin
              gap_load = 1'b1;
              state_d  = GAP;
            end
          end
        end else begin
          idx_dec = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          rep_load = 1'b1;
          state_d  = IDLE;
        end else if (gap_zero) begin
          state_d = SHIFT;
        end else begin
          gap_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore decode: every output follows registered state and bit index only.
  assign out   = (state_q == SHIFT) ? PATTERN[idx_val] : 1'b0;
  assign valid = (state_q == SHIFT);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign state = state_q;

endmodule

// File: tb/tb_seq_gen_7bit.sv
// Directed self-checking bench for seq_gen_7bit: three instances with gap
// lengths 0, 2 and 3, plus a behavioural 1011101 detector on the gap-3 output.
module tb_seq_gen_7bit;

  localparam logic [6:0] PAT = 7'b1011101;

  logic clk;
  logic rst_n;

  logic       start_s [3];
  logic [3:0] count_s [3];
  logic       abort_s [3];
  logic       out_w   [3];
  logic       valid_w [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic [2:0] state_w [3];

  int checkCount = 0;
  int errCount   = 0;

  seq_gen_7bit #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .count(count_s[0]), .abort(abort_s[0]),
    .out(out_w[0]), .valid(valid_w[0]), .busy(busy_w[0]), .done(done_w[0]), .state(state_w[0])
  );

  seq_gen_7bit #(.GAP_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .count(count_s[1]), .abort(abort_s[1]),
    .out(out_w[1]), .valid(valid_w[1]), .busy(busy_w[1]), .done(done_w[1]), .state(state_w[1])
  );

  seq_gen_7bit #(.GAP_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .count(count_s[2]), .abort(abort_s[2]),
    .out(out_w[2]), .valid(valid_w[2]), .busy(busy_w[2]), .done(done_w[2]), .state(state_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural sequence detector fed by the gap-3 instance: registered
  // history, so a match shows up in the cycle after the final frame bit.
  logic [6:0] detHist;
  int         detPulses  = 0;
  int         detOnTime  = 0;
  logic [2:0] prevState2 = 3'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) detHist <= 7'd0;
    else        detHist <= {detHist[5:0], out_w[2]};
  end

  // Count detector pulses, and those that land right after a frame's last bit.
  always @(negedge clk) begin
    if (detHist == PAT) begin
      detPulses++;
      if ((prevState2 == 3'd1) && ((state_w[2] == 3'd2) || (state_w[2] == 3'd3)))
        detOnTime++;
    end
    prevState2 = state_w[2];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a start pulse for one sampling edge; returns just after that edge.
  task automatic applyStimulus(input int i, input logic [3:0] c);
    @(negedge clk);
    start_s[i] = 1'b1;
    count_s[i] = c;
    @(posedge clk);
    #1;
    start_s[i] = 1'b0;
  endtask

  // Walk a whole burst cycle by cycle, optionally raising start mid-burst.
  task automatic checkBurst(input int i, input int n, input int g, input int injectAt, input string tag);
    int cyc = 0;
    for (int f = 0; f < n; f++) begin
      for (int b = 0; b < 7; b++) begin
        @(negedge clk);
        cyc++;
        start_s[i] = (cyc == injectAt);
        if (cyc == injectAt) count_s[i] = 4'd15;
        checkOutput({tag, "_out"},   32'(out_w[i]),   32'(PAT[6-b]));
        checkOutput({tag, "_valid"}, 32'(valid_w[i]), 32'd1);
        checkOutput({tag, "_state"}, 32'(state_w[i]), 32'd1);
      end
      if (f < n - 1) begin
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          cyc++;
          start_s[i] = 1'b0;
          checkOutput({tag, "_gapOut"},   32'(out_w[i]),   32'd0);
          checkOutput({tag, "_gapValid"}, 32'(valid_w[i]), 32'd0);
          checkOutput({tag, "_gapState"}, 32'(state_w[i]), 32'd2);
          checkOutput({tag, "_gapBusy"},  32'(busy_w[i]),  32'd1);
        end
      end
    end
    @(negedge clk);
    start_s[i] = 1'b0;
    checkOutput({tag, "_done"},      32'(done_w[i]),  32'd1);
    checkOutput({tag, "_doneState"}, 32'(state_w[i]), 32'd3);
    checkOutput({tag, "_doneBusy"},  32'(busy_w[i]),  32'd1);
    checkOutput({tag, "_doneValid"}, 32'(valid_w[i]), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_idleDone"},  32'(done_w[i]),  32'd0);
    checkOutput({tag, "_idleBusy"},  32'(busy_w[i]),  32'd0);
    checkOutput({tag, "_idleState"}, 32'(state_w[i]), 32'd0);
  endtask

  initial begin
    int pulsesBefore;
    int onTimeBefore;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      count_s[i] = 4'd0;
      abort_s[i] = 1'b0;
    end

    // Reset values on all three instances
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput("rstState", 32'(state_w[i]), 32'd0);
      checkOutput("rstOut",   32'(out_w[i]),   32'd0);
      checkOutput("rstValid", 32'(valid_w[i]), 32'd0);
      checkOutput("rstBusy",  32'(busy_w[i]),  32'd0);
      checkOutput("rstDone",  32'(done_w[i]),  32'd0);
    end
    rst_n = 1'b1;

    // Single frame, then two back-to-back frames
    applyStimulus(0, 4'd1);
    checkBurst(0, 1, 0, 0, "single");
    applyStimulus(0, 4'd2);
    checkBurst(0, 2, 0, 0, "b2b");

    // Three frames with two-cycle gaps
    applyStimulus(1, 4'd3);
    checkBurst(1, 3, 2, 0, "gapped");

    // Abort on the third bit of frame 2 (cycle 10 of the burst)
    applyStimulus(0, 4'd4);
    repeat (9) @(negedge clk);
    @(negedge clk);
    checkOutput("abortBit", 32'(out_w[0]), 32'd1);
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    checkOutput("abortState", 32'(state_w[0]), 32'd0);
    checkOutput("abortValid", 32'(valid_w[0]), 32'd0);
    checkOutput("abortDone",  32'(done_w[0]),  32'd0);
    checkOutput("abortBusy",  32'(busy_w[0]),  32'd0);
    @(negedge clk);
    checkOutput("abortNoDone", 32'(done_w[0]), 32'd0);
    applyStimulus(0, 4'd1);
    checkBurst(0, 1, 0, 0, "postAbort");

    // Asynchronous reset during a gap
    applyStimulus(1, 4'd2);
    repeat (7) @(negedge clk);
    @(negedge clk);
    checkOutput("preRstGap", 32'(state_w[1]), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncState", 32'(state_w[1]), 32'd0);
    checkOutput("asyncBusy",  32'(busy_w[1]),  32'd0);
    checkOutput("asyncValid", 32'(valid_w[1]), 32'd0);
    checkOutput("asyncOut",   32'(out_w[1]),   32'd0);
    checkOutput("asyncDone",  32'(done_w[1]),  32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstState", 32'(state_w[1]), 32'd0);
    checkOutput("postRstDone",  32'(done_w[1]),  32'd0);

    // Start with count 0 is ignored
    applyStimulus(0, 4'd0);
    @(negedge clk);
    checkOutput("zeroCntState", 32'(state_w[0]), 32'd0);
    checkOutput("zeroCntBusy",  32'(busy_w[0]),  32'd0);
    @(negedge clk);
    checkOutput("zeroCntDone",  32'(done_w[0]),  32'd0);

    // Start while busy is ignored: burst still ends after exactly 2 frames
    applyStimulus(0, 4'd2);
    checkBurst(0, 2, 0, 3, "busyStart");

    // Closed loop into the detector: five frames, three-cycle gaps
    pulsesBefore = detPulses;
    onTimeBefore = detOnTime;
    applyStimulus(2, 4'd5);
    checkBurst(2, 5, 3, 0, "loop");
    checkOutput("detPulses", 32'(detPulses - pulsesBefore), 32'd5);
    checkOutput("detOnTime", 32'(detOnTime - onTimeBefore), 32'd5);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
